// File: rtl/booth_mult8_issuer_if.sv
// Request, multiplier-core and result signals of the Booth multiplier issuer.
// The master modport is the issuer's view; slave is the environment's view.
interface booth_mult8_issuer_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [1:0]  in_mode;

  logic        core_start;
  logic [7:0]  core_mcand;
  logic [7:0]  core_mult;
  logic [1:0]  core_sign_mode;
  logic [15:0] core_product;
  logic        core_done;

  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_product;
  logic [7:0]  out_a;
  logic [7:0]  out_b;
  logic [1:0]  out_mode;
  logic        out_timeout;

  logic        busy;
  logic [15:0] txn_count;

  modport master (
    input  in_valid, in_a, in_b, in_mode, core_product, core_done, out_ready,
    output in_ready, core_start, core_mcand, core_mult, core_sign_mode,
           out_valid, out_product, out_a, out_b, out_mode, out_timeout,
           busy, txn_count
  );

  modport slave (
    output in_valid, in_a, in_b, in_mode, core_product, core_done, out_ready,
    input  in_ready, core_start, core_mcand, core_mult, core_sign_mode,
           out_valid, out_product, out_a, out_b, out_mode, out_timeout,
           busy, txn_count
  );
endinterface

// File: rtl/booth_mult8_issuer.sv
// One-at-a-time issuer for an 8x8 multiplier core: start in cycle 1, result L+2 (or timeout).
// No skid: in_ready drops from accept until the result handshake; result held until out_ready.
module booth_mult8_issuer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit PASS_OPERANDS  = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  booth_mult8_issuer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      next_state;
  logic        ready_q;
  logic [7:0]  mcand_q;
  logic [7:0]  mult_q;
  logic [1:0]  mode_q;
  logic [7:0]  tmo_cnt;
  logic [15:0] product_q;
  logic        timeout_q;
  logic [15:0] txn_cnt;
  logic        accept;
  logic        tmo_hit;

  assign accept  = (state == S_IDLE) && ready_q && bus.in_valid;
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // core_done is only looked at in WAIT, so a stale done during ISSUE is never captured.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = S_ISSUE;
      S_ISSUE: next_state = S_WAIT;
      S_WAIT:  if (bus.core_done || tmo_hit) next_state = S_HOLD;
      S_HOLD:  if (bus.out_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q   <= 1'b0;
      mcand_q   <= '0;
      mult_q    <= '0;
      mode_q    <= '0;
      tmo_cnt   <= '0;
      product_q <= '0;
      timeout_q <= 1'b0;
      txn_cnt   <= '0;
    end else begin
      // Registered so in_ready has no path from in_valid/out_ready.
      ready_q <= (next_state == S_IDLE);

      if (accept) begin
        mcand_q <= bus.in_a;
        mult_q  <= bus.in_b;
        mode_q  <= bus.in_mode;
      end

      if (state == S_ISSUE) begin
        tmo_cnt <= '0;
      end else if (state == S_WAIT) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end

      if (state == S_WAIT) begin
        if (bus.core_done) begin
          product_q <= bus.core_product;
          timeout_q <= 1'b0;
        end else if (tmo_hit) begin
          product_q <= '0;
          timeout_q <= 1'b1;
        end
      end

      if ((state == S_HOLD) && bus.out_ready) begin
        txn_cnt <= txn_cnt + 16'd1;
      end
    end
  end

  assign bus.in_ready       = ready_q;
  assign bus.core_start     = (state == S_ISSUE);
  assign bus.core_mcand     = mcand_q;
  assign bus.core_mult      = mult_q;
  assign bus.core_sign_mode = mode_q;
  assign bus.out_valid      = (state == S_HOLD);
  assign bus.out_product    = product_q;
  assign bus.out_timeout    = timeout_q;
  assign bus.out_a          = PASS_OPERANDS ? mcand_q : 8'd0;
  assign bus.out_b          = PASS_OPERANDS ? mult_q : 8'd0;
  assign bus.out_mode       = PASS_OPERANDS ? mode_q : 2'd0;
  assign bus.busy           = (state != S_IDLE);
  assign bus.txn_count      = txn_cnt;

endmodule

// File: tb/tb_booth_mult8_issuer.sv
// Directed bench for booth_mult8_issuer: a behavioural core answers each start after a
// per-transaction latency, expected results are queued at issue and checked on each handshake.
module tb_booth_mult8_issuer;

  typedef struct packed {
    logic [15:0] prod;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  mode;
    logic        tmo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_mult8_issuer_if bus();

  booth_mult8_issuer #(
    .TIMEOUT_CYCLES(8),
    .PASS_OPERANDS (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          core_lat = 0;
  logic [15:0] core_prod = 16'h0;
  logic [15:0] exp_txn = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural multiplier core: done pulse core_lat cycles after the start cycle.
  initial begin
    bus.core_done    = 1'b0;
    bus.core_product = 16'h0;
    forever begin
      @(negedge clk);
      if (bus.core_start && core_lat > 0) begin
        repeat (core_lat) @(posedge clk);
        #1;
        bus.core_done    = 1'b1;
        bus.core_product = core_prod;
        @(posedge clk);
        #1;
        bus.core_done    = 1'b0;
        bus.core_product = 16'hDEAD;
      end
    end
  end

  // Result monitor.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got product %h, expected no result", bus.out_product);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_product", 32'(bus.out_product), 32'(e.prod));
        check("out_a",       32'(bus.out_a),       32'(e.a));
        check("out_b",       32'(bus.out_b),       32'(e.b));
        check("out_mode",    32'(bus.out_mode),    32'(e.mode));
        check("out_timeout", 32'(bus.out_timeout), 32'(e.tmo));
      end
    end
  end

  // lat == 0 means the core never answers (timeout expected).
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] mode,
                         input logic [15:0] prod, input int lat, input int exp_cyc,
                         input int hold);
    exp_t e;
    int   n;
    int   cyc;
    logic acc;
    e.tmo  = (lat == 0);
    e.prod = e.tmo ? 16'h0 : prod;
    e.a    = a;
    e.b    = b;
    e.mode = mode;
    core_prod = prod;
    core_lat  = lat;
    sb.push_back(e);

    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_mode  = mode;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    check("accept", 32'(acc), 32'd1);

    @(negedge clk);
    check("core_start",     32'(bus.core_start),     32'd1);
    check("core_mcand",     32'(bus.core_mcand),     32'(a));
    check("core_mult",      32'(bus.core_mult),      32'(b));
    check("core_sign_mode", 32'(bus.core_sign_mode), 32'(mode));

    cyc = 1;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.out_valid && cyc < 300);
    check("valid_cycle", 32'(cyc), 32'(exp_cyc));

    // Stall the consumer while a second request is presented.
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_a     = ~a;
      bus.in_b     = ~b;
      @(negedge clk);
      check("hold_valid",   32'(bus.out_valid),   32'd1);
      check("hold_product", 32'(bus.out_product), 32'(e.prod));
      check("hold_a",       32'(bus.out_a),       32'(a));
      check("hold_ready",   32'(bus.in_ready),    32'd0);
      check("hold_start",   32'(bus.core_start),  32'd0);
    end

    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    exp_txn = exp_txn + 16'd1;
    @(negedge clk);
    check("txn_count",   32'(bus.txn_count), 32'(exp_txn));
    check("valid_after", 32'(bus.out_valid), 32'd0);
    check("ready_after", 32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = 8'h0;
    bus.in_b      = 8'h0;
    bus.in_mode   = 2'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",    32'(bus.in_ready),    32'd0);
    check("rst_out_valid",   32'(bus.out_valid),   32'd0);
    check("rst_busy",        32'(bus.busy),        32'd0);
    check("rst_core_start",  32'(bus.core_start),  32'd0);
    check("rst_txn_count",   32'(bus.txn_count),   32'd0);
    check("rst_core_mcand",  32'(bus.core_mcand),  32'd0);
    check("rst_out_product", 32'(bus.out_product), 32'd0);
    check("rst_out_timeout", 32'(bus.out_timeout), 32'd0);

    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);

    // signed x signed, -128 * -128
    run_txn(8'h80, 8'h80, 2'b11, 16'h4000, 4, 6, 0);
    // unsigned x unsigned, 255 * 255
    run_txn(8'hFF, 8'hFF, 2'b00, 16'hFE01, 1, 3, 0);
    // signed multiplicand x unsigned multiplier, -1 * 2
    run_txn(8'hFF, 8'h02, 2'b10, 16'hFFFE, 3, 5, 0);
    // 18 * 52 with the consumer stalled 10 cycles
    run_txn(8'h12, 8'h34, 2'b00, 16'h03A8, 2, 4, 10);
    // core never answers: 8 WAIT cycles then timeout result
    run_txn(8'h55, 8'h0F, 2'b01, 16'h04FB, 0, 10, 0);

    // Reset in the middle of WAIT; the core's later done must be ignored.
    core_prod = 16'h000F;
    core_lat  = 6;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_a     = 8'h03;
    bus.in_b     = 8'h05;
    bus.in_mode  = 2'b00;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    exp_txn = 16'h0;
    check("abort_in_ready",  32'(bus.in_ready),  32'd1);
    check("abort_txn_count", 32'(bus.txn_count), 32'(exp_txn));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(bus.out_valid), 32'd0);
      check("abort_idle",     32'(bus.busy),      32'd0);
    end

    // Counter wrap: preload near the top, then two more transactions.
    @(posedge clk); #1;
    dut.txn_cnt = 16'hFFFE;
    exp_txn     = 16'hFFFE;
    run_txn(8'h07, 8'h06, 2'b11, 16'h002A, 1, 3, 0);
    run_txn(8'hFE, 8'h03, 2'b11, 16'hFFFA, 2, 4, 0);
    check("wrap_txn_count", 32'(bus.txn_count), 32'h0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
